edge_dff_bank: RTL

Multi-channel, parametrised successor to the single edge-triggered D flip-flop with reset override. Holds CHANNELS independent WIDTH-bit registers with complementary outputs. Each channel can be overridden through a command port, either indefinitely or for a programmed number of cycles. While a channel is overridden, its shadow register keeps capturing data, so release restores the live value. The block sits between stimulus/control logic and downstream consumers as a test-and-debug hold point.

---
 rtl/edge_dff_bank_if.sv | 24 ++
 rtl/edge_dff_bank.sv | 125 ++++++++++++
 2 files changed

// File: rtl/edge_dff_bank_if.sv
// Override command channel for edge_dff_bank: a valid/ready handshake carrying
// the target channel, the operation, the forced value and the timed-hold length.
interface edge_dff_bank_if #(
  parameter int WIDTH  = 8,
  parameter int CHAN_W = 2,
  parameter int HOLD_W = 8
);
  logic              ovr_valid;
  logic              ovr_ready;
  logic [CHAN_W-1:0] ovr_chan;
  logic [1:0]        ovr_op;
  logic [WIDTH-1:0]  ovr_value;
  logic [HOLD_W-1:0] ovr_cycles;

  modport master (
    output ovr_valid, ovr_chan, ovr_op, ovr_value, ovr_cycles,
    input  ovr_ready
  );

  modport slave (
    input  ovr_valid, ovr_chan, ovr_op, ovr_value, ovr_cycles,
    output ovr_ready
  );
endinterface

// File: rtl/edge_dff_bank.sv
// Bank of CHANNELS edge-triggered registers with complementary outputs. Each channel
// can be forced, indefinitely or for a timed hold, while its shadow keeps capturing d.
module edge_dff_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2,
  parameter int HOLD_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  edge_dff_bank_if.slave            cmd,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       load_en,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qbar,
  output logic [CHANNELS-1:0]       ovr_active,
  output logic [CHANNELS-1:0]       expired,
  output logic                      ovr_err
);

  typedef enum logic [1:0] {
    OP_FORCE   = 2'd0,
    OP_RELEASE = 2'd1,
    OP_TIMED   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCED = 1'b1
  } state_t;

  localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W+1)'(CHANNELS);

  logic accept;
  logic illegal;
  logic cmd_force;
  logic cmd_timed;
  logic cmd_release;

  // Ready is withheld only while reset is asserted, so commands during reset are dropped.
  assign cmd.ovr_ready = ~reset;
  assign accept        = cmd.ovr_valid & cmd.ovr_ready;
  assign illegal       = (cmd.ovr_op == OP_ILLEGAL) || ({1'b0, cmd.ovr_chan} >= CHAN_LIM);
  assign cmd_force     = (cmd.ovr_op == OP_FORCE);
  assign cmd_timed     = (cmd.ovr_op == OP_TIMED) && (cmd.ovr_cycles != '0);
  // A zero-length timed force degenerates to a release.
  assign cmd_release   = (cmd.ovr_op == OP_RELEASE) ||
                         ((cmd.ovr_op == OP_TIMED) && (cmd.ovr_cycles == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_err <= 1'b0;
    end else begin
      ovr_err <= accept & illegal;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [CHAN_W-1:0] CID = CHAN_W'(c);

    state_t            state;
    logic [HOLD_W-1:0] cnt;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  shadow_next;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  qbar_r;
    logic              exp_r;
    logic              hit;

    assign shadow_next = load_en[c] ? d[c*WIDTH +: WIDTH] : shadow;
    assign hit         = accept & ~illegal & (cmd.ovr_chan == CID);

    // Commands take priority over the hold countdown, so a command at the expiry
    // edge replaces the override and suppresses the expired pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= NORMAL;
        cnt    <= '0;
        shadow <= '0;
        q_r    <= '0;
        qbar_r <= '1;
        exp_r  <= 1'b0;
      end else begin
        shadow <= shadow_next;
        exp_r  <= 1'b0;
        if (hit && cmd_force) begin
          state  <= FORCED;
          cnt    <= '0;
          q_r    <= cmd.ovr_value;
          qbar_r <= ~cmd.ovr_value;
        end else if (hit && cmd_timed) begin
          state  <= FORCED;
          cnt    <= cmd.ovr_cycles;
          q_r    <= cmd.ovr_value;
          qbar_r <= ~cmd.ovr_value;
        end else if (hit && cmd_release) begin
          state  <= NORMAL;
          cnt    <= '0;
          q_r    <= shadow_next;
          qbar_r <= ~shadow_next;
        end else if (state == FORCED) begin
          if (cnt == HOLD_W'(1)) begin
            state  <= NORMAL;
            cnt    <= '0;
            q_r    <= shadow_next;
            qbar_r <= ~shadow_next;
            exp_r  <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
          end
        end else begin
          q_r    <= shadow_next;
          qbar_r <= ~shadow_next;
        end
      end
    end

    assign q[c*WIDTH +: WIDTH]    = q_r;
    assign qbar[c*WIDTH +: WIDTH] = qbar_r;
    assign ovr_active[c]          = (state == FORCED);
    assign expired[c]             = exp_r;
  end

endmodule
